// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store.
// Data accesses win, fetch starvation is bounded, and read responses are routed back by owner tag.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic                dm_gnt,
  output logic                dm_rvalid,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } tag_t;

  logic [3:0] starve_cnt;
  tag_t       tag_pipe [RD_LAT];
  tag_t       tag_out;
  logic       rd_grant;

  // Grants are held low during reset so nothing reaches the memory before release.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    if_gnt = 1'b0;
    dm_gnt = 1'b0;
    if (reset_n) begin
      if (dm_req && !(if_req && starve_cnt == STARVE_LIM)) begin
        dm_gnt = 1'b1;
      end else if (if_req) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = if_gnt | dm_gnt;
    mem_we    = dm_gnt & dm_we;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dm_gnt) begin
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_be    = dm_we ? dm_be : '1;
    end else if (if_gnt) begin
      mem_addr = if_addr;
      mem_be   = '1;
    end
  end

  // Counts consecutive cycles fetch has lost to a data access; saturates at the limit.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      starve_cnt <= '0;
    end else if (dm_gnt && starve_cnt != STARVE_LIM) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  assign rd_grant = mem_en & ~mem_we;

  // NOTE: the tag pipeline is reset, unlike a data RAM, because a stale valid bit would emit a phantom response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LAT; i++) begin
        tag_pipe[i] <= '0;
      end
    end else begin
      tag_pipe[0].valid <= rd_grant;
      tag_pipe[0].owner <= dm_gnt ? OWN_DM : OWN_IF;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tag_out   = tag_pipe[RD_LAT-1];
  assign if_rvalid = tag_out.valid && (tag_out.owner == OWN_IF);
  assign dm_rvalid = tag_out.valid && (tag_out.owner == OWN_DM);
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives three arbiters (read latency 1, 2, 3) with shared stimulus and checks each
// against a cycle-level reference model of grants, memory strobes and read responses.
module tb_mem_port_arbiter;

  localparam int N          = 3;
  localparam int STARVE_MAX = 4;
  localparam int HIST       = 8192;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;

  logic        o_if_gnt    [N];
  logic        o_if_rvalid [N];
  logic [31:0] o_if_rdata  [N];
  logic        o_dm_gnt    [N];
  logic        o_dm_rvalid [N];
  logic [31:0] o_dm_rdata  [N];
  logic        o_mem_en    [N];
  logic        o_mem_we    [N];
  logic [3:0]  o_mem_be    [N];
  logic [31:0] o_mem_addr  [N];
  logic [31:0] o_mem_wdata [N];
  logic [31:0] mem_rdata   [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 64) ? 32'h0 : 32'h1000_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  for (genvar k = 0; k < N; k++) begin : g_inst
    logic [31:0] mem [256];
    logic [31:0] dly [3];

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      for (int i = 0; i < 3; i++) dly[i] = 32'hFFFF_FFFF;
    end

    // Memory environment: byte-enabled writes, reads delayed by k+1 cycles; garbage when not reading.
    always @(posedge clk) begin
      if (o_mem_en[k] && o_mem_we[k]) begin
        for (int b = 0; b < 4; b++) begin
          if (o_mem_be[k][b]) mem[o_mem_addr[k][9:2]][8*b +: 8] <= o_mem_wdata[k][8*b +: 8];
        end
      end
      dly[0] <= (o_mem_en[k] && !o_mem_we[k]) ? mem[o_mem_addr[k][9:2]] : 32'hFFFF_FFFF;
      dly[1] <= dly[0];
      dly[2] <= dly[1];
    end

    assign mem_rdata[k] = dly[k];

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .RD_LAT(k + 1), .STARVE_MAX(STARVE_MAX)
    ) u_dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(o_if_gnt[k]),
      .if_rvalid(o_if_rvalid[k]), .if_rdata(o_if_rdata[k]),
      .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_gnt(o_dm_gnt[k]),
      .dm_rvalid(o_dm_rvalid[k]), .dm_rdata(o_dm_rdata[k]),
      .mem_en(o_mem_en[k]), .mem_we(o_mem_we[k]), .mem_be(o_mem_be[k]),
      .mem_addr(o_mem_addr[k]), .mem_wdata(o_mem_wdata[k]), .mem_rdata(mem_rdata[k])
    );
  end

  // Reference model: per-cycle history of read grants (owner, data); latency-L response is history[cyc-L].
  int          cyc = 4;
  int          m_wait = 0;
  bit          m_if_gnt = 1'b0;
  bit          m_dm_gnt = 1'b0;
  logic [31:0] ref_mem [256];
  bit          h_v  [HIST];
  bit          h_dm [HIST];
  logic [31:0] h_d  [HIST];

  initial for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

  always @(negedge clk) begin
    bit          e_if, e_dm, e_rif, e_rdm;
    logic [31:0] e_addr;
    int          g;
    e_if = 1'b0;
    e_dm = 1'b0;
    if (!reset_n) begin
      m_wait = 0;
      for (int j = 0; j <= N; j++) h_v[cyc-j] = 1'b0;
    end else begin
      e_dm = dm_req && !(if_req && m_wait >= STARVE_MAX);
      e_if = if_req && !e_dm;
      e_addr = e_dm ? dm_addr : if_addr;
      h_v[cyc]  = e_if || (e_dm && !dm_we);
      h_dm[cyc] = e_dm;
      h_d[cyc]  = ref_mem[e_addr[9:2]];
      if (e_dm && dm_we) begin
        for (int b = 0; b < 4; b++) begin
          if (dm_be[b]) ref_mem[e_addr[9:2]][8*b +: 8] = dm_wdata[8*b +: 8];
        end
      end
      m_wait = (if_req && !e_if) ? ((m_wait < STARVE_MAX) ? m_wait + 1 : m_wait) : 0;
    end
    for (int k = 0; k < N; k++) begin
      g = cyc - (k + 1);
      e_rif = h_v[g] && !h_dm[g];
      e_rdm = h_v[g] && h_dm[g];
      check($sformatf("L%0d if_gnt", k+1), 32'(o_if_gnt[k]), 32'(e_if));
      check($sformatf("L%0d dm_gnt", k+1), 32'(o_dm_gnt[k]), 32'(e_dm));
      check($sformatf("L%0d mem_en", k+1), 32'(o_mem_en[k]), 32'(e_if || e_dm));
      check($sformatf("L%0d mem_we", k+1), 32'(o_mem_we[k]), 32'(e_dm && dm_we));
      check($sformatf("L%0d if_rvalid", k+1), 32'(o_if_rvalid[k]), 32'(e_rif));
      check($sformatf("L%0d dm_rvalid", k+1), 32'(o_dm_rvalid[k]), 32'(e_rdm));
      check($sformatf("L%0d if_rdata", k+1), o_if_rdata[k], e_rif ? h_d[g] : 32'h0);
      check($sformatf("L%0d dm_rdata", k+1), o_dm_rdata[k], e_rdm ? h_d[g] : 32'h0);
      if (e_if || e_dm) begin
        check($sformatf("L%0d mem_addr", k+1), o_mem_addr[k], e_dm ? dm_addr : if_addr);
        check($sformatf("L%0d mem_be", k+1), 32'(o_mem_be[k]),
              32'((e_dm && dm_we) ? dm_be : 4'hF));
      end
      if (e_dm && dm_we) check($sformatf("L%0d mem_wdata", k+1), o_mem_wdata[k], dm_wdata);
      if (!reset_n) begin
        check($sformatf("L%0d rst mem_addr", k+1), o_mem_addr[k], 32'h0);
        check($sformatf("L%0d rst mem_wdata", k+1), o_mem_wdata[k], 32'h0);
      end
    end
    m_if_gnt = e_if;
    m_dm_gnt = e_dm;
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both requesters hold loads/fetches; expects dm x4 then fetch, repeating, and owner-correct data at L=1.
  task automatic contention(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      if_req = 1'b1; if_addr = 32'h40;
      dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
      @(negedge clk);
      check("cont if_gnt", 32'(o_if_gnt[0]), 32'((i % 5) == 4));
      check("cont dm_gnt", 32'(o_dm_gnt[0]), 32'((i % 5) != 4));
      if (i > 0) begin
        if (((i - 1) % 5) == 4) begin
          check("cont if_rvalid", 32'(o_if_rvalid[0]), 32'd1);
          check("cont if_rdata", o_if_rdata[0], 32'h1000_0010);
        end else begin
          check("cont dm_rvalid", 32'(o_dm_rvalid[0]), 32'd1);
          check("cont dm_rdata", o_dm_rdata[0], 32'h1000_0008);
        end
      end
    end
    step();
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; if_req = 1'b1; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        check("rst if_gnt", 32'(o_if_gnt[k]), 32'd0);
        check("rst mem_en", 32'(o_mem_en[k]), 32'd0);
      end
    end

    // Fetch-only stream after release.
    step(); reset_n = 1'b1; if_addr = 32'h0;
    @(negedge clk); check("fetch gnt0", 32'(o_if_gnt[0]), 32'd1);
    step(); if_addr = 32'h4;
    @(negedge clk); check("fetch gnt1", 32'(o_if_gnt[0]), 32'd1);
    check("fetch data0", o_if_rdata[0], 32'h1000_0000);
    step(); if_addr = 32'h8;
    @(negedge clk); check("fetch data1", o_if_rdata[0], 32'h1000_0001);
    step(); if_req = 1'b0;
    @(negedge clk); check("fetch data2", o_if_rdata[0], 32'h1000_0002);
    check("fetch idle gnt", 32'(o_if_gnt[0]), 32'd0);

    contention(10);

    // Partial store beats a waiting fetch, then fetch reads it back.
    step();
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("store dm_gnt", 32'(o_dm_gnt[0]), 32'd1);
    check("store mem_we", 32'(o_mem_we[0]), 32'd1);
    check("store mem_be", 32'(o_mem_be[0]), 32'h3);
    step(); dm_req = 1'b0; dm_we = 1'b0; if_addr = 32'h100;
    @(negedge clk);
    check("store no rvalid", 32'(o_dm_rvalid[0]), 32'd0);
    check("rdback if_gnt", 32'(o_if_gnt[0]), 32'd1);
    step(); if_req = 1'b0;
    @(negedge clk); check("rdback L1", o_if_rdata[0], 32'h0000_BEEF);
    step();
    @(negedge clk); check("rdback L2", o_if_rdata[1], 32'h0000_BEEF);
    step();
    @(negedge clk);
    check("rdback L3 valid", 32'(o_if_rvalid[2]), 32'd1);
    check("rdback L3", o_if_rdata[2], 32'h0000_BEEF);

    // Load granted, then reset while it is in flight: it must never return.
    step(); dm_req = 1'b1; dm_addr = 32'h20;
    @(negedge clk); check("midrst dm_gnt", 32'(o_dm_gnt[1]), 32'd1);
    step(); dm_req = 1'b0; reset_n = 1'b0;
    step();
    step(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) check("midrst dm_rvalid", 32'(o_dm_rvalid[k]), 32'd0);
      step();
    end

    contention(10);

    // Randomized traffic with held requests and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      if (!reset_n) reset_n = ($urandom_range(1) == 0);
      else if ($urandom_range(199) == 0) reset_n = 1'b0;
      if (!(if_req && !m_if_gnt)) begin
        if_req  = ($urandom_range(99) < 60);
        if_addr = {25'b0, 5'($urandom), 2'b00};
      end
      if (!(dm_req && !m_dm_gnt)) begin
        dm_req   = ($urandom_range(99) < 50);
        dm_we    = 1'($urandom_range(1));
        dm_be    = 4'($urandom);
        dm_addr  = {25'b0, 5'($urandom), 2'b00};
        dm_wdata = $urandom;
      end
    end
    step(); reset_n = 1'b1; if_req = 1'b0; dm_req = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous memory between two requesters of the pipelined RISC-V core: instruction fetch (if_*) and load/store (dm_*).
- Arbitrates per cycle and gives data accesses priority, since they belong to the older instruction.
- A starvation counter bounds how long fetch can wait.
- Tracks outstanding reads through the memory's fixed read latency and routes each response back to its owner.

Parameters:
ADDR_W, 32, address width.
DATA_W, 32, data width; must be a multiple of 8.
RD_LAT, 1, memory read latency in cycles (1..4).
STARVE_MAX, 4, maximum consecutive cycles fetch may lose arbitration (1..15).

Ports:
clk  in  1  clock, rising edge.
reset_n  in  1  asynchronous reset, active low.
if_req  in  1  fetch read request.
if_addr  in  ADDR_W  fetch address.
if_gnt  out  1  fetch request accepted this cycle.
if_rvalid  out  1  fetch read data valid.
if_rdata  out  DATA_W  fetch read data.
dm_req  in  1  load/store request.
dm_we  in  1  1 = store, 0 = load.
dm_be  in  DATA_W/8  store byte enables.
dm_addr  in  ADDR_W  load/store address.
dm_wdata  in  DATA_W  store data.
dm_gnt  out  1  load/store accepted this cycle.
dm_rvalid  out  1  load data valid.
dm_rdata  out  DATA_W  load data.
mem_en  out  1  memory access strobe.
mem_we  out  1  memory write enable.
mem_be  out  DATA_W/8  memory byte enables.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory read data, valid RD_LAT cycles after a read strobe.

Behaviour:
- Reset (reset_n=0, async):
  - starve_cnt=0 and the tag pipeline is cleared.
  - All gnt/rvalid/mem_en/mem_we outputs are 0.
  - Reads in flight at reset are dropped; no rvalid for them ever appears after release.
- Grant logic is combinational from the current cycle's requests and starve_cnt:
  - Only one requester: it is granted.
  - Both requesting, starve_cnt==STARVE_MAX: fetch wins.
  - Both requesting otherwise: dm wins.
  - No request: mem_en=0.
  - At most one gnt is high per cycle.
- Memory drive:
  - mem_* carries the winner's request in the grant cycle; mem_en = if_gnt|dm_gnt.
  - Fetch: mem_we=0, mem_be=all ones.
  - dm: mem_we=dm_we; mem_be=dm_be for stores, all ones for loads; mem_wdata=dm_wdata.
  - mem_addr/mem_wdata are don't-care when mem_en=0, but are driven to 0 out of reset.
- Requester rule: address, data and we are held stable while req=1 and gnt=0. The arbiter does not latch them.
- starve_cnt (registered):
  - Cleared on if_gnt or when if_req=0.
  - Incremented when if_req=1 and dm_gnt=1.
  - Saturates at STARVE_MAX.
- Response tracking:
  - Each read grant pushes a tag {valid, owner} into an RD_LAT-deep shift register. Stores and idle cycles push valid=0.
  - The tag leaving the last stage drives if_rvalid or dm_rvalid in the cycle mem_rdata is valid.
  - rdata is mem_rdata, zeroed when the matching rvalid is low.
  - One new request may be granted every cycle; back-to-back reads are fully pipelined with no bubbles.
- Stores complete on grant and produce no rvalid.
- Simultaneous grant and response: a new grant in the same cycle as an rvalid is legal and independent.
- Latency: grant is 0 cycles after req; rvalid comes RD_LAT cycles after gnt.

Test Plan:
- Reset: hold reset_n=0 with if_req=1 -> all gnt, rvalid and mem_en stay 0. Release -> if_gnt=1 in the same cycle.
- Fetch only: if_req=1, addr 0x00,0x04,0x08 on consecutive cycles, RD_LAT=1 -> if_gnt=1 each cycle; if_rvalid on cycles 1,2,3 with the memory words at those addresses.
- Contention with STARVE_MAX=4: if_req and dm_req (loads) both held high -> dm_gnt for 4 cycles, if_gnt on the 5th, then dm again. Each dm_rvalid/if_rvalid appears exactly 1 cycle after its own grant with the correct owner.
- Store priority: dm store of 0xDEADBEEF, be=0011, to 0x100 while fetch requests -> mem_we=1, mem_be=0011, no dm_rvalid. A subsequent fetch of 0x100 returns 0x0000BEEF from a zeroed memory.
- RD_LAT=3, interleaved fetch/load grants -> rvalids arrive 3 cycles after their grants, in grant order, never both high in the same cycle.
- Reset mid-read: assert reset_n=0 one cycle after a load grant with RD_LAT=2 -> no dm_rvalid after release; starve_cnt restarts at 0.
